outport_alloc: RTL and testbench

- Per-output-port switch allocator for the router.
- Shares one output port, including its downstream vcmux and link, among NIN input-port requesters.
- Arbitration is round-robin and wormhole-locked: once a requester is granted, it owns the port until its tail flit transfers.
- Keeps one credit counter per downstream virtual channel and blocks any transfer whose target VC has zero credits.

---
 rtl/outport_alloc_if.sv | 28 ++
 rtl/outport_alloc.sv | 169 ++++++++++++++++
 tb/tb_outport_alloc.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/outport_alloc_if.sv
// Request/grant/credit bundle between the input-port requesters and one output-port allocator.
interface outport_alloc_if #(
    parameter int NIN  = 5,
    parameter int NVC  = 2,
    parameter int VCW  = 1,
    parameter int CNTW = 3
);
    logic [NIN-1:0]      req;
    logic [NIN*VCW-1:0]  req_vc;
    logic [NIN-1:0]      valid_in;
    logic [NIN-1:0]      tail_in;
    logic [NVC-1:0]      credit_in;
    logic [NIN-1:0]      grant;
    logic [VCW-1:0]      grant_vc;
    logic                xfer;
    logic [NVC*CNTW-1:0] credit_cnt;
    logic                credit_err;

    modport master (
        output req, req_vc, valid_in, tail_in, credit_in,
        input  grant, grant_vc, xfer, credit_cnt, credit_err
    );

    modport slave (
        input  req, req_vc, valid_in, tail_in, credit_in,
        output grant, grant_vc, xfer, credit_cnt, credit_err
    );
endinterface

// File: rtl/outport_alloc.sv
// Output-port switch allocator: round-robin, wormhole-locked arbitration over NIN
// requesters with one downstream credit counter per VC gating every flit transfer.
module outport_alloc_credit #(
    parameter int CNTW    = 3,
    parameter int CREDITS = 4
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            ovf_o
);
    logic [CNTW-1:0] cnt_q, cnt_d;

    // A return into a full counter is dropped and reported instead of wrapping.
    assign ovf_o = inc_i & ~dec_i & (cnt_q == CNTW'(CREDITS));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i & ~dec_i & ~ovf_o)
            cnt_d = cnt_q + CNTW'(1);
        else if (dec_i & ~inc_i)
            cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst_) cnt_q <= CNTW'(CREDITS);
        else      cnt_q <= cnt_d;
    end
endmodule

module outport_alloc #(
    parameter int NIN     = 5,
    parameter int NVC     = 2,
    parameter int VCW     = 1,
    parameter int CREDITS = 4,
    parameter int CNTW    = 3
) (
    input  logic          clk,
    input  logic          rst_,
    outport_alloc_if.slave bus
);
    localparam int PTRW = (NIN > 1) ? $clog2(NIN) : 1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                  state_q, state_d;
    logic [NIN-1:0]          grant_q, grant_d;
    logic [VCW-1:0]          grant_vc_q, grant_vc_d;
    logic [PTRW-1:0]         ptr_q, ptr_d;
    logic                    credit_err_q, credit_err_d;

    logic [NVC-1:0][CNTW-1:0] cnt;
    logic [NVC-1:0]          ovf, dec;
    logic [NIN-1:0]          eligible, elig_rot, win_oh;
    logic [2*NIN-1:0]        elig_dbl;
    logic                    any_elig;
    logic [PTRW:0]           win_sum;
    logic [PTRW-1:0]         win, owner;
    logic [VCW-1:0]          win_vc;
    logic                    own_valid, own_tail, own_credit, xfer;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NIN; i++)
            eligible[i] = bus.req[i] & (cnt[bus.req_vc[i*VCW +: VCW]] != '0);
    end

    // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
    assign elig_dbl = {eligible, eligible} >> ptr_q;
    assign elig_rot = elig_dbl[NIN-1:0];

    always_comb begin
        any_elig = 1'b0;
        win_sum  = '0;
        for (int k = 0; k < NIN; k++) begin
            if (!any_elig && elig_rot[k]) begin
                any_elig = 1'b1;
                win_sum  = {1'b0, ptr_q} + (PTRW+1)'(k);
            end
        end
        if (win_sum >= (PTRW+1)'(NIN))
            win_sum = win_sum - (PTRW+1)'(NIN);
    end

    assign win = win_sum[PTRW-1:0];

    always_comb begin
        win_oh = '0;
        win_vc = '0;
        owner  = '0;
        for (int i = 0; i < NIN; i++) begin
            win_oh[i] = any_elig & (win == PTRW'(i));
            if (win_oh[i])  win_vc = bus.req_vc[i*VCW +: VCW];
            if (grant_q[i]) owner  = PTRW'(i);
        end
    end

    assign own_valid  = |(bus.valid_in & grant_q);
    assign own_tail   = |(bus.tail_in & grant_q);
    assign own_credit = (cnt[grant_vc_q] != '0);
    assign xfer       = (state_q == LOCKED) & own_valid & own_credit;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_vc_d = grant_vc_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d    = LOCKED;
                    grant_d    = win_oh;
                    grant_vc_d = win_vc;
                end
            end
            LOCKED: begin
                // Only the owner's tail releases the port; its req level is irrelevant.
                if (xfer & own_tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner == PTRW'(NIN-1)) ? '0 : owner + PTRW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign credit_err_d = credit_err_q | (|ovf);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_vc_q   <= '0;
            ptr_q        <= '0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_vc_q   <= grant_vc_d;
            ptr_q        <= ptr_d;
            credit_err_q <= credit_err_d;
        end
    end

    for (genvar v = 0; v < NVC; v++) begin : g_vc
        assign dec[v] = xfer & (grant_vc_q == VCW'(v));
        outport_alloc_credit #(.CNTW(CNTW), .CREDITS(CREDITS)) u_credit (
            .clk   (clk),
            .rst_  (rst_),
            .inc_i (bus.credit_in[v]),
            .dec_i (dec[v]),
            .cnt_o (cnt[v]),
            .ovf_o (ovf[v])
        );
    end

    assign bus.grant      = grant_q;
    assign bus.grant_vc   = grant_vc_q;
    assign bus.xfer       = xfer;
    assign bus.credit_cnt = cnt;
    assign bus.credit_err = credit_err_q;
endmodule

// File: tb/tb_outport_alloc.sv
// Bench for outport_alloc: directed table and corner sequences plus random traffic
// checked every cycle against a packet-level reference model.
module tb_outport_alloc;
    localparam int NIN = 5, NVC = 2, VCW = 1, CREDITS = 4, CNTW = 3;

    logic clk, rst_;
    outport_alloc_if #(.NIN(NIN), .NVC(NVC), .VCW(VCW), .CNTW(CNTW)) bus ();

    outport_alloc #(.NIN(NIN), .NVC(NVC), .VCW(VCW), .CREDITS(CREDITS), .CNTW(CNTW)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, n_xfer = 0;

    // reference model: owner index (-1 = free), owner VC, pointer, credit pool
    int m_own, m_vc, m_ptr;
    int m_cnt[NVC];
    bit m_err;

    logic [NIN-1:0] s_grant;
    logic           s_xfer, s_err;
    logic [NVC*CNTW-1:0] s_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_own = -1; m_vc = 0; m_ptr = 0; m_err = 0;
        for (int v = 0; v < NVC; v++) m_cnt[v] = CREDITS;
    endtask

    function automatic int vc_of(input int i);
        return int'(bus.req_vc[i*VCW +: VCW]);
    endfunction

    function automatic bit m_xfer();
        if (m_own < 0) return 1'b0;
        return bus.valid_in[m_own] && (m_cnt[m_vc] > 0);
    endfunction

    function automatic logic [NVC*CNTW-1:0] m_cnt_vec();
        logic [NVC*CNTW-1:0] e;
        e = '0;
        for (int v = 0; v < NVC; v++) e[v*CNTW +: CNTW] = CNTW'(m_cnt[v]);
        return e;
    endfunction

    task automatic m_update();
        bit x;
        int vc_old;
        if (rst_) begin
            m_reset();
            return;
        end
        x = m_xfer();
        vc_old = m_vc;
        if (m_own < 0) begin
            for (int k = 0; k < NIN; k++) begin
                int i;
                i = (m_ptr + k) % NIN;
                if (bus.req[i] && m_cnt[vc_of(i)] > 0) begin
                    m_own = i;
                    m_vc = vc_of(i);
                    break;
                end
            end
        end else if (x && bus.tail_in[m_own]) begin
            m_ptr = (m_own + 1) % NIN;
            m_own = -1;
        end
        for (int v = 0; v < NVC; v++) begin
            bit dec, inc;
            dec = x && (vc_old == v);
            inc = bus.credit_in[v];
            if (inc && !dec && m_cnt[v] == CREDITS) m_err = 1;
            else m_cnt[v] = m_cnt[v] - int'(dec) + int'(inc);
        end
    endtask

    // One clock: compare against the model before the edge, then advance the model.
    task automatic step();
        @(negedge clk);
        chk("grant", 32'(bus.grant), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        chk("grant_vc", 32'(bus.grant_vc), 32'(m_vc));
        chk("xfer", 32'(bus.xfer), 32'(m_xfer()));
        chk("credit_cnt", 32'(bus.credit_cnt), 32'(m_cnt_vec()));
        chk("credit_err", 32'(bus.credit_err), 32'(m_err));
        s_grant = bus.grant; s_xfer = bus.xfer; s_cnt = bus.credit_cnt; s_err = bus.credit_err;
        if (bus.xfer === 1'b1) n_xfer++;
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.req = '0; bus.req_vc = '0; bus.valid_in = '0; bus.tail_in = '0; bus.credit_in = '0;
    endtask

    task automatic do_reset();
        clr_in();
        rst_ = 1'b1;
        step();
        step();
        rst_ = 1'b0;
    endtask

    typedef struct {
        logic [NIN-1:0] req, valid, tail;
        logic [NVC-1:0] cred;
        logic [NIN-1:0] eg;
        logic           ex;
    } vec_t;
    vec_t tbl[13];

    initial begin
        int x0;
        clr_in();
        rst_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst_ = 1'b0;

        // 1: idle after reset
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_grant", 32'(s_grant), 32'd0);
            chk("idle_xfer", 32'(s_xfer), 32'd0);
            chk("idle_cnt", 32'(s_cnt), 32'h24);
            chk("idle_err", 32'(s_err), 32'd0);
        end

        // 2: round-robin between requesters 0 and 2, 2-flit packets
        for (int c = 0; c < 13; c++) begin
            bit xf, tl;
            xf = (c % 3) != 0;
            tl = (c % 3) == 2;
            tbl[c].req = 5'b00101; tbl[c].valid = 5'b11111;
            tbl[c].tail = tl ? 5'b00101 : 5'b00000;
            tbl[c].cred = xf ? 2'b01 : 2'b00;
            tbl[c].ex = xf;
            tbl[c].eg = !xf ? 5'b00000 : (((c / 3) % 2) == 0) ? 5'b00001 : 5'b00100;
        end
        do_reset();
        for (int c = 0; c < 13; c++) begin
            bus.req = tbl[c].req; bus.valid_in = tbl[c].valid;
            bus.tail_in = tbl[c].tail; bus.credit_in = tbl[c].cred;
            step();
            chk($sformatf("rr_grant[%0d]", c), 32'(s_grant), 32'(tbl[c].eg));
            chk($sformatf("rr_xfer[%0d]", c), 32'(s_xfer), 32'(tbl[c].ex));
        end

        // 3: credit stall on VC0, 6-flit packet from requester 1
        do_reset();
        bus.req = 5'b00010; bus.valid_in = 5'b00010;
        step();
        x0 = n_xfer;
        repeat (4) step();
        chk("stall_xfers", 32'(n_xfer - x0), 32'd4);
        step();
        chk("stall_xfer0", 32'(s_xfer), 32'd0);
        chk("stall_grant", 32'(s_grant), 32'b00010);
        chk("stall_cnt0", 32'(s_cnt[2:0]), 32'd0);
        step();
        chk("stall_hold", 32'(s_xfer), 32'd0);
        bus.credit_in = 2'b01; step();
        bus.credit_in = 2'b00; step();
        chk("stall_resume", 32'(s_xfer), 32'd1);
        bus.credit_in = 2'b01; step();
        bus.credit_in = 2'b00; bus.tail_in = 5'b00010; step();
        chk("stall_tail", 32'(s_xfer), 32'd1);
        bus.tail_in = '0; bus.req = '0; bus.valid_in = '0; step();
        chk("stall_release", 32'(s_grant), 32'd0);
        chk("stall_total", 32'(n_xfer - x0), 32'd6);

        // 4: same-cycle inc/dec on VC1, then the zero-credit gate
        do_reset();
        bus.req = 5'b01000; bus.req_vc = 5'b01000; bus.valid_in = 5'b01000;
        step();
        bus.credit_in = 2'b10; step();
        chk("simul_xfer", 32'(s_xfer), 32'd1);
        bus.credit_in = 2'b00; step();
        chk("simul_cnt1", 32'(s_cnt[5:3]), 32'd4);
        repeat (2) step();
        bus.tail_in = 5'b01000; step();
        bus.tail_in = '0; bus.req = 5'b10001; bus.req_vc = 5'b10000; bus.valid_in = '0;
        step();
        chk("gate_cnt1", 32'(s_cnt[5:3]), 32'd0);
        step();
        chk("gate_grant", 32'(s_grant), 32'b00001);

        // 5: credit overflow is sticky
        do_reset();
        bus.credit_in = 2'b01; step();
        bus.credit_in = 2'b00; step();
        chk("ovf_cnt0", 32'(s_cnt[2:0]), 32'd4);
        chk("ovf_err", 32'(s_err), 32'd1);
        repeat (20) step();
        chk("ovf_sticky", 32'(s_err), 32'd1);

        // 6: req drop mid-packet, then reset mid-packet
        do_reset();
        bus.req = 5'b00100; bus.valid_in = 5'b00100;
        step(); step();
        bus.req = '0; step();
        chk("drop_hold", 32'(s_grant), 32'b00100);
        bus.tail_in = 5'b00100; step();
        chk("drop_tail", 32'(s_grant), 32'b00100);
        bus.tail_in = '0; bus.valid_in = '0; step();
        chk("drop_release", 32'(s_grant), 32'd0);
        bus.req = 5'b00100; bus.valid_in = 5'b00100;
        step(); step();
        rst_ = 1'b1; step();
        rst_ = 1'b0; bus.req = 5'b11111; bus.valid_in = '0; step();
        chk("rst_grant", 32'(s_grant), 32'd0);
        chk("rst_cnt", 32'(s_cnt), 32'h24);
        step();
        chk("rst_ptr", 32'(s_grant), 32'b00001);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            bus.req = 5'($urandom);
            bus.req_vc = 5'($urandom);
            bus.valid_in = 5'($urandom) | 5'($urandom);
            for (int i = 0; i < NIN; i++) bus.tail_in[i] = ($urandom_range(0, 2) == 0);
            for (int v = 0; v < NVC; v++) bus.credit_in[v] = ($urandom_range(0, 2) == 0);
            rst_ = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_ = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
